sequence_gen: RTL
=================

# sequence_gen

Serial pattern transmitter that produces the single-bit stream consumed by the FSM sequence detectors. It accepts a WIDTH-bit word through a ready/start handshake and shifts it out MSB-first on `x`, one bit per clock, with a `valid` qualifier. After each frame it inserts GAP idle cycles. It pairs with a downstream detector, for example a `1011` detector loaded with `data = 4'b1011`, to form a self-checking serial link.

## Interface
- `WIDTH`, default 4: frame length in bits, legal range 2..32.
- `GAP`, default 1: number of idle cycles after each frame, legal range 0..15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset. Synchronous and active-low: sampled on the rising edge of `clk`, and `rst==0` resets the block.
- `start`  input  1  request to send. Sampled only while `ready==1`.
- `data`  input  WIDTH  word to transmit. Captured on the accepting edge.
- `ready`  output  1  block is idle and can accept `start`.
- `x`  output  1  serial bit, MSB first.
- `valid`  output  1  `x` carries a frame bit this cycle.
- `done`  output  1  one-cycle pulse, coincident with the last bit of a frame.

## Operation
- All outputs are registered. Output values are decoded from the current state and the shift register, with no combinational path from inputs to outputs.
- States:
  - IDLE
  - SEND
  - GAP
- Reset (`rst==0` at a clock edge) applies regardless of state:
  - Next state is IDLE.
  - Shift register and counters clear to 0.
  - `ready=1`, `x=0`, `valid=0`, `done=0`.
- IDLE:
  - Outputs: `ready=1`, `valid=0`, `x=0`.
  - If `start==1` at an edge: load `data` into the shift register, set the bit counter to WIDTH-1, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - Outputs: `ready=0`, `valid=1`, `x = shreg[WIDTH-1]`.
  - Each edge: shift left with zero fill and decrement the counter.
  - `done=1` while the counter equals 0, i.e. during the last bit.
  - At the edge that ends the last bit: go to GAP if GAP>0, else go to IDLE.
- GAP:
  - Outputs: `ready=0`, `valid=0`, `x=0`.
  - Gap counter runs GAP cycles, then the state returns to IDLE.
- `start` and `data` are ignored outside IDLE. Changing `data` mid-frame does not affect the frame in progress.
- If `start` is held high continuously, frames transmit back-to-back, each separated by GAP cycles plus the one IDLE acceptance cycle.
- Counter widths:
  - Bit counter is ceil(log2(WIDTH)) bits.
  - Gap counter is 4 bits.
  - Neither counter wraps in legal operation.
- Illegal or unused state encodings return to IDLE on the next edge, with outputs held at their IDLE values.

## Timing
- Accepting edge E0 is the edge where `start==1` and `ready==1`.
- Cycle n is the cycle following edge E(n-1):
  - Cycles 1..WIDTH: bit `data[WIDTH-n]` on `x`, with `valid=1`.
  - Cycle WIDTH: `done=1`.
  - Cycles WIDTH+1..WIDTH+GAP: GAP state.
  - Cycle WIDTH+GAP+1: `ready=1`.
- Latency from the accepting edge to the first bit is 1 cycle.
- Frame period is WIDTH+GAP+1 cycles.
- Reset mid-frame: the frame is truncated. In the cycle after the reset edge, `x=0`, `valid=0`, `done=0` and `ready=1`. No `done` pulse is produced for the truncated frame.
- Reset and `start` active at the same edge: reset wins and nothing is loaded.

## Test plan
- Reset check: hold `rst=0` for 2 edges with `start=1` -> `ready=1`, `x=0`, `valid=0`, `done=0`, and no frame starts.
- Single frame, WIDTH=4, GAP=1, `data=4'b1011`, `start` pulsed at E0:
  - `x` = 1,0,1,1 in cycles 1–4 with `valid=1`.
  - `done=1` only in cycle 4.
  - `ready` is 0 in cycles 1–5 and 1 in cycle 6.
  - Loopback into a `1011` detector raises its `z` one cycle after cycle 4.
- Continuous `start=1`, `data` switched from 4'b1011 to 4'b0110 during the first frame:
  - First frame is 1,0,1,1 with no corruption.
  - Second frame 0,1,1,0 starts at cycle 7.
  - `done` pulses at cycles 4 and 10.
- Busy-ignore: assert `start` in cycles 2 and 5 while `ready==0` -> no extra frame is started, and the next frame begins only after `start` is sampled in a `ready==1` cycle.
- Reset mid-frame: apply `rst=0` at E2 during `data=4'b1011` -> cycle 3 shows `x=0`, `valid=0`, `ready=1`, and `done` never pulses for that frame.
- WIDTH=8, GAP=0, `data=8'hA5`:
  - `x` = 1,0,1,0,0,1,0,1 in cycles 1–8.
  - `done` at cycle 8.
  - `ready=1` at cycle 9.
  - A second `start` sampled at E9 produces its first bit in cycle 10.

Source files
------------

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: accepts a WIDTH-bit word on a ready/start handshake,
// shifts it out MSB-first with a valid qualifier, then idles for GAP cycles.
module sequence_gen #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             valid_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  logic             ready_q, ready_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // Next-state, datapath and next-output decode; outputs derive from next state only.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_SEND;
          shreg_d  = data_i;
          bitcnt_d = BIT_LOAD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SEND: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bitcnt_q == '0) begin
          bitcnt_d = '0;
          if (GAP > 0) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_LOAD;
          end else begin
            state_d  = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (gapcnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
        gapcnt_d = 4'd0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_SEND);
    x_d     = valid_d & shreg_d[WIDTH-1];
    done_d  = valid_d & (bitcnt_d == '0);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= 4'd0;
      ready_q  <= 1'b1;
      x_q      <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      ready_q  <= ready_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign x_o     = x_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule
